shift_add_mul_seq: RTL and testbench

//  Sequential signed shift-add multiplier: iterative counterpart of the combinational 64x64 shift-add array.

---
 rtl/shift_add_mul_seq_pkg.sv | 7 +
 rtl/shift_add_mul_seq_step.sv | 17 +
 rtl/shift_add_mul_seq.sv | 74 +++++++
 tb/tb_shift_add_mul_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/shift_add_mul_seq_pkg.sv
// mul_pkg: shared FSM state type and parameter legality check for the sequential multiplier
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic bit bpc_ok(input int w, input int b);
    return b >= 1 && b <= w && (w % b) == 0;
  endfunction
endpackage

// File: rtl/shift_add_mul_seq_step.sv
// shift_add_step: adds the shifted multiplicand for each set multiplier bit; the final sign bit carries negative weight
module shift_add_step #(
  parameter int W2 = 128,
  parameter int B  = 4
) (
  input  logic [W2-1:0] i_acc,
  input  logic [W2-1:0] i_mcand,
  input  logic [B-1:0]  i_slice,
  input  logic          i_last,
  output logic [W2-1:0] o_acc
);
  always_comb begin
    o_acc = i_acc;
    for (int j = 0; j < B; j++)
      if (i_slice[j]) o_acc = (i_last && j == B - 1) ? o_acc - (i_mcand << j) : o_acc + (i_mcand << j);
  end
endmodule

// File: rtl/shift_add_mul_seq.sv
// shift_add_mul_seq: iterative signed shift-add multiplier with valid/ready in and out
module shift_add_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               busy
);
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam bit BPC_OK = bpc_ok(WIDTH, BITS_PER_CYCLE);
  if (!BPC_OK) begin : g_bpc_chk
    $error("BITS_PER_CYCLE must divide WIDTH");
  end
  state_t             r_state;
  logic [2*WIDTH-1:0] r_mcand, r_acc, r_result;
  logic [WIDTH-1:0]   r_mplr;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc;
  logic               w_last;
  assign w_last     = r_cnt == CNT_W'(1);
  assign in_ready   = r_state == IDLE;
  assign out_valid  = r_state == DONE;
  assign busy       = r_state != IDLE;
  assign out_result = r_result;
  shift_add_step #(.W2(2*WIDTH), .B(BITS_PER_CYCLE)) u_step (
    .i_acc  (r_acc),
    .i_mcand(r_mcand),
    .i_slice(r_mplr[BITS_PER_CYCLE-1:0]),
    .i_last (w_last),
    .o_acc  (w_acc)
  );
  // r_result is separate from r_acc so the product survives the next accept's clear
  always_ff @(posedge clk)
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplr   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else
      case (r_state)
        IDLE: if (in_valid) begin
          r_state <= RUN;
          r_mcand <= {{WIDTH{in_a[WIDTH-1]}}, in_a};
          r_mplr  <= in_b;
          r_acc   <= '0;
          r_cnt   <= CNT_W'(STEPS);
        end
        RUN: begin
          r_acc   <= w_acc;
          r_mcand <= r_mcand << BITS_PER_CYCLE;
          r_mplr  <= r_mplr >> BITS_PER_CYCLE;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_state  <= DONE;
            r_result <= w_acc;
          end
        end
        DONE: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_shift_add_mul_seq.sv
// tb_shift_add_mul_seq: directed and randomized checks of the multiplier at 4, 1 and 64 bits per cycle
module tb_shift_add_mul_seq;
  localparam int W = 64;
  localparam int STEPS [3] = '{16, 64, 1};
  logic clk = 1'b0;
  logic rst;
  logic in_valid [3], in_ready [3], out_valid [3], out_ready [3], busy [3];
  logic [W-1:0] in_a [3], in_b [3];
  logic [2*W-1:0] out_result [3];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  shift_add_mul_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(out_result[0]), .busy(busy[0]));
  shift_add_mul_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(out_result[1]), .busy(busy[1]));
  shift_add_mul_seq #(.WIDTH(W), .BITS_PER_CYCLE(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_a(in_a[2]), .in_b(in_b[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_result(out_result[2]), .busy(busy[2]));
  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                       output logic [2*W-1:0] res, output int lat, output int rdy_bad);
    int t;
    t = 0;
    in_a[k] = a;
    in_b[k] = b;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && t < 200) begin
      tick();
      t++;
    end
    tick();
    in_valid[k] = 1'b0;
    lat = 0;
    rdy_bad = 0;
    while (!out_valid[k] && lat < 200) begin
      rdy_bad += int'(in_ready[k]);
      tick();
      lat++;
    end
    repeat (stall) begin
      rdy_bad += int'(in_ready[k]) + int'(!out_valid[k]);
      tick();
    end
    rdy_bad += int'(in_ready[k]);
    res = out_result[k];
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask
  task automatic rand_run(input int k, input int n);
    logic [W-1:0] a, b;
    logic signed [W-1:0] sa, sb;
    logic signed [2*W-1:0] p;
    logic [2*W-1:0] res;
    int lat, rb;
    for (int i = 0; i < n; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 16 == 0) a = {1'b1, 63'b0};
      if (i % 16 == 1) b = '1;
      if (i % 16 == 2) a = '0;
      if (i % 16 == 3) begin
        a = {1'b1, 63'b0};
        b = {1'b1, 63'b0};
      end
      sa = a;
      sb = b;
      p = sa * sb;
      do_op(k, a, b, int'($urandom_range(0, 3)), res, lat, rb);
      chk($sformatf("rand%0d_%0d_prod", k, i), res, p);
      chk($sformatf("rand%0d_%0d_lat", k, i), 128'(lat + rb), 128'(STEPS[k]));
    end
  endtask
  logic [W-1:0] va [6], vb [6];
  logic [2*W-1:0] ve [6];
  logic [2*W-1:0] res;
  int lat, rb, bad;
  initial begin
    va[0] = -64'sd7; vb[0] = 64'sd6;  ve[0] = -128'sd42;
    va[1] = 64'sd7;  vb[1] = -64'sd6; ve[1] = -128'sd42;
    va[2] = -64'sd7; vb[2] = -64'sd6; ve[2] = 128'sd42;
    va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h8000_0000_0000_0000;
    ve[3] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
    va[4] = '1; vb[4] = '1; ve[4] = 128'd1;
    va[5] = '0; vb[5] = '1; ve[5] = 128'd0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      in_a[k] = '0;
      in_b[k] = '0;
    end
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_busy", 128'(busy[0]), 128'd0);
    chk("rst_result", out_result[0], 128'd0);
    do_op(0, 64'd3, 64'd5, 0, res, lat, rb);
    chk("mul_3x5", res, 128'd15);
    chk("lat_3x5", 128'(lat), 128'd16);
    chk("rdy_low_3x5", 128'(rb), 128'd0);
    chk("idle_ready", 128'(in_ready[0]), 128'd1);
    chk("idle_valid", 128'(out_valid[0]), 128'd0);
    for (int i = 0; i < 6; i++) begin
      do_op(0, va[i], vb[i], 1, res, lat, rb);
      chk($sformatf("vec%0d_prod", i), res, ve[i]);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'd16);
      chk($sformatf("vec%0d_rdy", i), 128'(rb), 128'd0);
    end
    in_a[0] = 64'd11;
    in_b[0] = 64'd13;
    in_valid[0] = 1'b1;
    tick();
    in_a[0] = 64'd100;
    in_b[0] = 64'd100;
    lat = 0;
    while (!out_valid[0] && lat < 200) begin
      tick();
      lat++;
    end
    chk("stall_lat", 128'(lat), 128'd16);
    bad = 0;
    repeat (10) begin
      tick();
      bad += int'(out_valid[0] !== 1'b1 || out_result[0] !== 128'd143 || in_ready[0] !== 1'b0);
    end
    chk("stall_hold", 128'(bad), 128'd0);
    chk("stall_result", out_result[0], 128'd143);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    chk("release_valid", 128'(out_valid[0]), 128'd0);
    chk("release_ready", 128'(in_ready[0]), 128'd1);
    chk("release_busy", 128'(busy[0]), 128'd0);
    chk("release_hold", out_result[0], 128'd143);
    in_a[0] = 64'd5;
    in_b[0] = 64'd5;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", 128'(in_ready[0]), 128'd1);
    chk("mid_rst_valid", 128'(out_valid[0]), 128'd0);
    chk("mid_rst_busy", 128'(busy[0]), 128'd0);
    chk("mid_rst_result", out_result[0], 128'd0);
    bad = 0;
    repeat (20) begin
      tick();
      bad += int'(out_valid[0]);
    end
    chk("mid_rst_no_valid", 128'(bad), 128'd0);
    do_op(0, 64'd2, 64'd9, 0, res, lat, rb);
    chk("after_rst_prod", res, 128'd18);
    chk("after_rst_lat", 128'(lat), 128'd16);
    fork
      rand_run(0, 1000);
      rand_run(1, 300);
      rand_run(2, 1000);
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
